// File: rtl/count_sampler.sv
// Snapshots count on trig or counter wrap into a DEPTH-entry FIFO tagged with a wrap epoch.
// Optional macro COUNT_SAMPLER_DROP_CNT_EN adds a saturating drop_cnt output.
module count_sampler #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = 8
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             count,
  input  logic                         done,
  input  logic                         trig,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_count,
  output logic [EPOCH_W-1:0]           out_epoch,
  output logic                         out_wrap,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
`ifdef COUNT_SAMPLER_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + EPOCH_W + 1;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [EPOCH_W-1:0] epoch;
  logic               done_q;

  logic wrap_ev;
  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  assign wrap_ev   = done & ~done_q;
  assign push_req  = trig | wrap_ev;
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (level == LVL_W'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign {out_count, out_epoch, out_wrap} = mem[rd_ptr];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      epoch  <= '0;
      done_q <= 1'b0;
      level  <= '0;
    end else begin
      done_q <= done;
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        epoch  <= '0;
        level  <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= {count, epoch, wrap_ev};
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (wrap_ev) epoch <= epoch + EPOCH_W'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
    end
  end

`ifdef COUNT_SAMPLER_DROP_CNT_EN
  assign overflow = |drop_cnt;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_count_sampler.sv
// Bench for count_sampler: queue-based reference model checked every cycle, plus literal expectations.
// Two instances share stimulus: EPOCH_W=8 and EPOCH_W=2 (epoch wrap).
module tb_count_sampler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        clr;
  logic [15:0] count;
  logic        done;
  logic        trig;
  logic        out_ready;

  logic        v1, w1, o1, v2, w2, o2;
  logic [15:0] c1, c2;
  logic [7:0]  e1;
  logic [1:0]  e2;
  logic [2:0]  l1, l2;
`ifdef COUNT_SAMPLER_DROP_CNT_EN
  logic [7:0]  d1, d2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_sampler #(.WIDTH(16), .DEPTH(DEPTH), .EPOCH_W(8)) u1 (
    .clk(clk), .a_rst(a_rst), .clr(clr), .count(count), .done(done), .trig(trig),
    .out_valid(v1), .out_ready(out_ready), .out_count(c1), .out_epoch(e1),
    .out_wrap(w1), .level(l1), .overflow(o1)
`ifdef COUNT_SAMPLER_DROP_CNT_EN
    , .drop_cnt(d1)
`endif
  );

  count_sampler #(.WIDTH(16), .DEPTH(DEPTH), .EPOCH_W(2)) u2 (
    .clk(clk), .a_rst(a_rst), .clr(clr), .count(count), .done(done), .trig(trig),
    .out_valid(v2), .out_ready(out_ready), .out_count(c2), .out_epoch(e2),
    .out_wrap(w2), .level(l2), .overflow(o2)
`ifdef COUNT_SAMPLER_DROP_CNT_EN
    , .drop_cnt(d2)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of samples plus epoch / drop bookkeeping.
  typedef struct {
    int cnt;
    int ep;
    bit wr;
  } ent_t;

  ent_t q[$];
  int   m_epoch = 0;
  int   m_drops = 0;
  bit   m_ovf   = 0;
  bit   m_done  = 0;

  always @(posedge clk) begin
    bit   wrap_e;
    bit   req;
    bit   pop_e;
    ent_t e;
    if (!a_rst) begin
      q.delete();
      m_epoch = 0;
      m_drops = 0;
      m_ovf   = 0;
      m_done  = 0;
    end else begin
      wrap_e = done && !m_done;
      req    = trig || wrap_e;
      pop_e  = (q.size() != 0) && out_ready;
      m_done = done;
      if (clr) begin
        q.delete();
        m_epoch = 0;
        m_drops = 0;
        m_ovf   = 0;
      end else begin
        if (pop_e) void'(q.pop_front());
        if (req) begin
          if (q.size() < DEPTH) begin
            e.cnt = int'(count);
            e.ep  = m_epoch;
            e.wr  = wrap_e;
            q.push_back(e);
          end else begin
            m_ovf = 1;
            m_drops++;
          end
        end
        if (wrap_e) m_epoch++;
      end
    end
    #1;
    chk("valid", int'(v1), int'(q.size() != 0));
    chk("level", int'(l1), q.size());
    chk("overflow", int'(o1), int'(m_ovf));
    chk("valid_e2", int'(v2), int'(q.size() != 0));
    chk("level_e2", int'(l2), q.size());
`ifdef COUNT_SAMPLER_DROP_CNT_EN
    chk("drop_cnt", int'(d1), (m_drops > 255) ? 255 : m_drops);
`endif
    if (q.size() != 0) begin
      chk("count", int'(c1), q[0].cnt);
      chk("epoch", int'(e1), q[0].ep % 256);
      chk("wrap", int'(w1), int'(q[0].wr));
      chk("epoch_e2", int'(e2), q[0].ep % 4);
      chk("count_e2", int'(c2), q[0].cnt);
    end
  end

  task automatic step(input bit t, input bit d, input bit r, input int cnt);
    trig      = t;
    done      = d;
    out_ready = r;
    count     = 16'(cnt);
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b0; clr = 1'b0; count = '0; done = 1'b0; trig = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(v1), 0);
    chk("rst_level", int'(l1), 0);
    a_rst = 1'b1;

    // In-order capture with the consumer stalled, then drained.
    step(1, 0, 0, 5);
    step(1, 0, 0, 9);
    step(1, 0, 0, 12);
    step(0, 0, 0, 0);
    chk("t2_level", int'(l1), 3);
    chk("t2_head0", int'(c1), 5);
    step(0, 0, 1, 0);
    chk("t2_head1", int'(c1), 9);
    chk("t2_epoch", int'(e1), 0);
    chk("t2_wrap", int'(w1), 0);
    step(0, 0, 1, 0);
    chk("t2_head2", int'(c1), 12);
    step(0, 0, 1, 0);
    chk("t2_empty", int'(v1), 0);

    // done held high produces a single wrap entry.
    step(0, 1, 0, 16'hFFFF);
    step(0, 1, 0, 16'hFFFF);
    step(0, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0);
    chk("t3_level", int'(l1), 1);
    chk("t3_count", int'(c1), 16'hFFFF);
    chk("t3_epoch", int'(e1), 0);
    chk("t3_wrap", int'(w1), 1);
    step(1, 0, 0, 77);
    chk("t3_level2", int'(l1), 2);
    step(0, 0, 1, 0);
    chk("t3_trig_count", int'(c1), 77);
    chk("t3_trig_epoch", int'(e1), 1);
    chk("t3_trig_wrap", int'(w1), 0);
    step(0, 0, 1, 0);
    chk("t3_empty", int'(v1), 0);

    // Overflow: six pushes into four entries keeps the first four.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 100 + i);
    step(0, 0, 0, 0);
    chk("t4_level", int'(l1), 4);
    chk("t4_ovf", int'(o1), 1);
    chk("t4_head", int'(c1), 100);
`ifdef COUNT_SAMPLER_DROP_CNT_EN
    chk("t4_drop", int'(d1), 2);
`endif
    step(1, 0, 1, 200);
    chk("t4_full_pp_level", int'(l1), 4);
    chk("t4_full_pp_head", int'(c1), 101);
    step(0, 0, 1, 0);
    chk("t4_pop_level", int'(l1), 3);
    chk("t4_pop_head", int'(c1), 102);

    // Asynchronous reset mid-burst takes effect without a clock edge.
    #2;
    a_rst = 1'b0;
    #1;
    chk("t1_valid", int'(v1), 0);
    chk("t1_level", int'(l1), 0);
    chk("t1_ovf", int'(o1), 0);
    chk("t1_count", int'(c1), 0);
    @(negedge clk);
    a_rst = 1'b1;

    // trig coinciding with a done edge yields one wrap entry.
    step(1, 1, 0, 33);
    step(0, 0, 0, 0);
    chk("t5_level", int'(l1), 1);
    chk("t5_wrap", int'(w1), 1);
    chk("t5_epoch", int'(e1), 0);
    chk("t5_count", int'(c1), 33);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 40 + i);
    chk("t5_ovf_set", int'(o1), 1);
    clr = 1'b1;
    step(1, 0, 0, 44);
    clr = 1'b0;
    chk("t5_clr_level", int'(l1), 0);
    chk("t5_clr_ovf", int'(o1), 0);
    step(1, 0, 0, 45);
    chk("t5_post_count", int'(c1), 45);
    chk("t5_post_epoch", int'(e1), 0);
    step(0, 0, 1, 0);
    chk("t5_empty", int'(v1), 0);

    // Five wrap events: the 2-bit epoch instance rolls over to 0.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 500 + i);
      chk("t6_epoch8", int'(e1), i);
      chk("t6_epoch2", int'(e2), i % 4);
      chk("t6_wrap", int'(w1), 1);
      step(0, 0, 1, 0);
    end
    chk("t6_empty", int'(v1), 0);

    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
